// File: rtl/ghrd.sv
// DE10-Nano user-logic top: 640x480@60 VGA raster with colour-bar / grey-ramp
// test pattern, debounced pattern toggle on KEY[1], reset request on KEY[0].
module ghrd #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HB_BITS         = 26,
  parameter int unsigned H_ACTIVE        = 640,
  parameter int unsigned H_FP            = 16,
  parameter int unsigned H_SYNC          = 96,
  parameter int unsigned H_BP            = 48,
  parameter int unsigned V_ACTIVE        = 480,
  parameter int unsigned V_FP            = 10,
  parameter int unsigned V_SYNC          = 2,
  parameter int unsigned V_BP            = 33
) (
  input  logic       FPGA_CLK1_50,
  input  logic       rst,
  input  logic       FPGA_CLK2_50,
  input  logic       FPGA_CLK3_50,
  input  logic [1:0] KEY,
  output logic [7:0] LED,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_DE,
  output logic [9:0] VGA_X,
  output logic [9:0] VGA_Y,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned BAR_W    = H_ACTIVE / 8;
  localparam int unsigned DB_W     = $clog2(DEBOUNCE_CYCLES) + 1;

  logic clk;
  assign clk = FPGA_CLK1_50;

  // The spare board clocks are deliberately left dangling.
  logic unused_clks;
  assign unused_clks = &{1'b0, FPGA_CLK2_50, FPGA_CLK3_50};

  // Synchronisers power up released (buttons idle high) and are never reset.
  logic [1:0] key_meta = '1;
  logic [1:0] key_sync = '1;

  always_ff @(posedge clk) begin
    key_meta <= KEY;
    key_sync <= key_meta;
  end

  logic rst_i;
  assign rst_i = rst | ~key_sync[0];

  logic       pix_en;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      pix_en <= 1'b0;
      h_cnt  <= '0;
      v_cnt  <= '0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (h_cnt == 10'(H_TOTAL - 1)) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == 10'(V_TOTAL - 1)) ? '0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

  logic key1_db;
  logic [DB_W-1:0] db_cnt;
  logic mode;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      key1_db <= 1'b1;
      db_cnt  <= '0;
      mode    <= 1'b0;
    end else if (key_sync[1] == key1_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      key1_db <= key_sync[1];
      db_cnt  <= '0;
      // Only an accepted press (level going low) flips the pattern.
      if (!key_sync[1]) mode <= ~mode;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  logic        de_c;
  logic        hs_c;
  logic        vs_c;
  logic [2:0]  bar;
  logic [23:0] rgb_c;

  always_comb begin
    de_c  = (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
    hs_c  = !((h_cnt >= 10'(HS_START)) && (h_cnt < 10'(HS_END)));
    vs_c  = !((v_cnt >= 10'(VS_START)) && (v_cnt < 10'(VS_END)));
    bar   = 3'(h_cnt / 10'(BAR_W));
    rgb_c = '0;
    if (de_c) begin
      if (mode) begin
        rgb_c = {3{h_cnt[9:2]}};
      end else begin
        case (bar)
          3'd0:    rgb_c = 24'hFFFFFF;
          3'd1:    rgb_c = 24'hFFFF00;
          3'd2:    rgb_c = 24'h00FFFF;
          3'd3:    rgb_c = 24'h00FF00;
          3'd4:    rgb_c = 24'hFF00FF;
          3'd5:    rgb_c = 24'hFF0000;
          3'd6:    rgb_c = 24'h0000FF;
          default: rgb_c = 24'h000000;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      VGA_HS <= 1'b1;
      VGA_VS <= 1'b1;
      VGA_DE <= 1'b0;
      VGA_X  <= '0;
      VGA_Y  <= '0;
      VGA_R  <= '0;
      VGA_G  <= '0;
      VGA_B  <= '0;
    end else begin
      VGA_HS <= hs_c;
      VGA_VS <= vs_c;
      VGA_DE <= de_c;
      VGA_X  <= de_c ? h_cnt : '0;
      VGA_Y  <= de_c ? v_cnt : '0;
      {VGA_R, VGA_G, VGA_B} <= rgb_c;
    end
  end

  logic [HB_BITS-1:0] hb_cnt;

  always_ff @(posedge clk) begin
    if (rst_i) hb_cnt <= '0;
    else       hb_cnt <= hb_cnt + HB_BITS'(1);
  end

  assign LED = {hb_cnt[HB_BITS-1], 5'b00000, ~VGA_VS, mode};

endmodule

// File: tb/tb_ghrd.sv
// Scoreboard bench for ghrd: a per-cycle raster model derived from elapsed
// pixel time feeds a queue that a negedge monitor drains and compares.
module tb_ghrd;

  localparam int DB  = 8;
  localparam int HB  = 4;
  localparam int HA  = 640, HFP = 16, HSY = 96, HBP = 48;
  localparam int VA  = 8,   VFP = 2,  VSY = 2,  VBP = 2;
  localparam int HT  = HA + HFP + HSY + HBP;
  localparam int VT  = VA + VFP + VSY + VBP;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk2 = 1'b0;
  logic       clk3 = 1'b0;
  logic [1:0] key;
  logic [7:0] led;
  logic       hs, vs, de;
  logic [9:0] x, y;
  logic [7:0] r, g, b;

  always #10 clk = ~clk;

  ghrd #(
    .DEBOUNCE_CYCLES(DB), .HB_BITS(HB),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
  ) dut (
    .FPGA_CLK1_50(clk), .rst(rst), .FPGA_CLK2_50(clk2), .FPGA_CLK3_50(clk3),
    .KEY(key), .LED(led), .VGA_HS(hs), .VGA_VS(vs), .VGA_DE(de),
    .VGA_X(x), .VGA_Y(y), .VGA_R(r), .VGA_G(g), .VGA_B(b)
  );

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] rgb;
    logic [7:0]  led;
  } vga_t;

  typedef struct {
    vga_t v;
    bit   chk_mode;
  } exp_t;

  exp_t sb[$];
  int   cmp_cnt  = 0;
  int   fail_cnt = 0;

  // Reference state: k = clock edges since the last internal reset edge.
  bit       live       = 1'b0;
  int       k          = 0;
  bit [1:0] m_s1       = 2'b11;
  bit [1:0] m_s2       = 2'b11;
  bit       mode_m     = 1'b0;
  bit       mode_known = 1'b1;
  bit       rst_edge   = 1'b0;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  function automatic vga_t model_out(int kk, bit md);
    vga_t o;
    int n, h, v;
    logic [7:0] grey;
    o    = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    if (kk == 0) return o;
    n    = (kk - 1) / 2;
    h    = n % HT;
    v    = (n / HT) % VT;
    o.de = (h < HA) && (v < VA);
    o.hs = !(h >= HA + HFP && h < HA + HFP + HSY);
    o.vs = !(v >= VA + VFP && v < VA + VFP + VSY);
    if (o.de) begin
      o.x  = 10'(h);
      o.y  = 10'(v);
      grey = 8'(h / 4);
      o.rgb = md ? {grey, grey, grey} : bars[h / (HA / 8)];
    end
    o.led = {1'((kk >> (HB - 1)) & 1), 5'b00000, ~o.vs, md};
    return o;
  endfunction

  always @(posedge clk) begin
    bit   re;
    exp_t e;
    re   = rst | ~m_s2[0];
    m_s2 = m_s1;
    m_s1 = key;
    rst_edge = re;
    if (re) begin
      k      = 0;
      live   = 1'b1;
      mode_m = 1'b0;
    end else if (live) begin
      k++;
    end
    if (live) begin
      e.v        = model_out(k, mode_m);
      e.chk_mode = mode_known;
      sb.push_back(e);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    vga_t act, ex;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      act = {hs, vs, de, x, y, r, g, b, led};
      ex  = e.v;
      if (!e.chk_mode) begin
        act.rgb    = '0;
        ex.rgb     = '0;
        act.led[0] = 1'b0;
        ex.led[0]  = 1'b0;
      end
      cmp_cnt++;
      if (act !== ex) begin
        fail_cnt++;
        $display("FAIL raster k=%0d: got hs=%b vs=%b de=%b x=%0d y=%0d rgb=%h led=%b, want hs=%b vs=%b de=%b x=%0d y=%0d rgb=%h led=%b",
                 k, act.hs, act.vs, act.de, act.x, act.y, act.rgb, act.led,
                 ex.hs, ex.vs, ex.de, ex.x, ex.y, ex.rgb, ex.led);
      end
    end
  end

  // Independent sync-width and per-frame active-area counters.
  int   hs_run = 0, vs_run = 0, de_cnt = 0;
  bit   fr_ok  = 1'b0;
  logic hs_q   = 1'b1, vs_q = 1'b1;

  always @(negedge clk) begin
    if (live) begin
      if (rst_edge) begin
        hs_run = 0;
        vs_run = 0;
        de_cnt = 0;
        fr_ok  = 1'b0;
      end else begin
        if (!hs) hs_run++;
        else if (!hs_q) begin
          cmp_cnt++;
          if (hs_run != 2 * HSY) begin
            fail_cnt++;
            $display("FAIL hsync_width: got %0d clocks, want %0d", hs_run, 2 * HSY);
          end
          hs_run = 0;
        end
        if (!vs) vs_run++;
        else if (!vs_q) begin
          cmp_cnt++;
          if (vs_run != 2 * VSY * HT) begin
            fail_cnt++;
            $display("FAIL vsync_width: got %0d clocks, want %0d", vs_run, 2 * VSY * HT);
          end
          vs_run = 0;
        end
        if (de) de_cnt++;
        if (!vs && vs_q) begin
          if (fr_ok) begin
            cmp_cnt++;
            if (de_cnt != 2 * HA * VA) begin
              fail_cnt++;
              $display("FAIL frame_de_count: got %0d clocks, want %0d", de_cnt, 2 * HA * VA);
            end
          end
          fr_ok  = 1'b1;
          de_cnt = 0;
        end
      end
      hs_q = hs;
      vs_q = vs;
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pixel(int target, int budget);
    int c = 0;
    while (((k - 1) / 2) < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    cmp_cnt++;
    if (c >= budget) begin
      fail_cnt++;
      $display("FAIL frame_wait: reached pixel %0d after %0d cycles, want %0d", (k - 1) / 2, c, target);
    end
  endtask

  // Hold KEY[1] low long enough to be accepted; mode is unchecked only while
  // the debounce acceptance point is in flight.
  task automatic press(int hold);
    mode_known = 1'b0;
    key[1]     = 1'b0;
    tick(15);
    mode_m     = ~mode_m;
    mode_known = 1'b1;
    tick(hold - 15);
    key[1]     = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    key = 2'b11;
    tick(4);
    rst = 1'b0;
    tick(30);

    key = 2'b10;
    tick(50);
    key = 2'b11;

    repeat (4) begin
      tick($urandom_range(200, 50));
      key[1] = 1'b0;
      tick($urandom_range(5, 1));
      key[1] = 1'b1;
    end

    wait_pixel(HT * VT + 10, 2 * (HT * VT + 20) + 10);

    press($urandom_range(40, 20));
    tick(5000);
    press($urandom_range(40, 20));
    tick(12000);

    tick($urandom_range(1500, 100));
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(2000);

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
